addn_seq: RTL and testbench

//  Multi-cycle WIDTH-bit adder/subtractor. Processes CHUNK bits per clock with a carry held between cycles.
//  Has valid/ready handshakes on its input and output.

---
 rtl/lc3_arith_pkg.sv | 23 ++
 rtl/add_chunk.sv | 28 ++
 rtl/full_adder.sv | 11 +
 rtl/addn_seq.sv | 124 ++++++++++++
 tb/tb_addn_seq.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/lc3_arith_pkg.sv
// rtl/lc3_arith_pkg.sv - shared FSM encoding and sizing helpers for the chunked adder
package lc3_arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int num_chunks(input int width, input int chunk);
        return width / chunk;
    endfunction

    // A single-chunk build still needs a 1-bit counter to keep the datapath uniform.
    function automatic int cnt_width(input int nchunk);
        return (nchunk > 1) ? $clog2(nchunk) : 1;
    endfunction

    function automatic bit chunk_ok(input int width, input int chunk);
        return (chunk > 0) && (width % chunk == 0);
    endfunction

endpackage

// File: rtl/add_chunk.sv
// rtl/add_chunk.sv - combinational CHUNK-bit ripple adder built from full_adder cells
module add_chunk #(
    parameter int CHUNK = 4
) (
    input  logic             cyi,
    input  logic [CHUNK-1:0] op_a,
    input  logic [CHUNK-1:0] op_b,
    output logic [CHUNK-1:0] sum,
    output logic             cyo,
    output logic             msb_cyi
);
    logic [CHUNK:0] c;

    assign c[0] = cyi;

    for (genvar i = 0; i < CHUNK; i++) begin : g_bit
        full_adder u_fa (
            .a  (op_a[i]),
            .b  (op_b[i]),
            .ci (c[i]),
            .s  (sum[i]),
            .co (c[i+1])
        );
    end

    assign cyo     = c[CHUNK];
    assign msb_cyi = c[CHUNK-1];
endmodule

// File: rtl/full_adder.sv
// rtl/full_adder.sv - one-bit full adder cell
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

// File: rtl/addn_seq.sv
// rtl/addn_seq.sv - multi-cycle WIDTH-bit add/subtract, CHUNK bits per cycle, with N/Z/C/V flags
module addn_seq
    import lc3_arith_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cyi,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cyo,
    output logic             ovf,
    output logic             neg,
    output logic             zero
);
    localparam int NCHUNK = num_chunks(WIDTH, CHUNK);
    localparam int CNT_W  = cnt_width(NCHUNK);

    if (!chunk_ok(WIDTH, CHUNK)) begin : g_bad_chunk
        $error("addn_seq: WIDTH must be a non-zero multiple of CHUNK");
    end

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic               carry_q;

    logic [CHUNK-1:0]   ca;
    logic [CHUNK-1:0]   cb;
    logic [CHUNK-1:0]   cs;
    logic               c_out;
    logic               c_msb;
    logic [WIDTH-1:0]   sum_next;
    logic               last;

    always_comb begin
        ca = '0;
        cb = '0;
        for (int i = 0; i < NCHUNK; i++) begin
            if (cnt == CNT_W'(i)) begin
                ca = a_q[i*CHUNK +: CHUNK];
                cb = b_q[i*CHUNK +: CHUNK];
            end
        end
    end

    add_chunk #(.CHUNK(CHUNK)) u_add_chunk (
        .cyi     (carry_q),
        .op_a    (ca),
        .op_b    (cb),
        .sum     (cs),
        .cyo     (c_out),
        .msb_cyi (c_msb)
    );

    always_comb begin
        sum_next = sum;
        for (int i = 0; i < NCHUNK; i++) begin
            if (cnt == CNT_W'(i)) begin
                sum_next[i*CHUNK +: CHUNK] = cs;
            end
        end
    end

    assign last      = (cnt == CNT_W'(NCHUNK - 1));
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            sum     <= '0;
            cyo     <= 1'b0;
            ovf     <= 1'b0;
            neg     <= 1'b0;
            zero    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= op_a;
                        b_q     <= sub ? ~op_b : op_b;
                        carry_q <= sub ? ~cyi : cyi;
                        cnt     <= '0;
                        state   <= BUSY;
                    end
                end
                BUSY: begin
                    sum     <= sum_next;
                    carry_q <= c_out;
                    cnt     <= cnt + CNT_W'(1);
                    if (last) begin
                        cyo   <= c_out;
                        // Carry into vs. out of the MSB differ exactly when the sign overflows.
                        ovf   <= c_msb ^ c_out;
                        neg   <= sum_next[WIDTH-1];
                        zero  <= (sum_next == '0);
                        cnt   <= '0;
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_addn_seq.sv
// tb/tb_addn_seq.sv - self-checking bench for addn_seq at CHUNK=4, 16 and 1
module tb_addn_seq;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [15:0] op_a, op_b;
    logic        cyi, sub;
    logic        in_valid  [3];
    logic        in_ready  [3];
    logic        out_valid [3];
    logic        out_ready [3];
    logic [15:0] sum_o     [3];
    logic        cyo_o     [3];
    logic        ovf_o     [3];
    logic        neg_o     [3];
    logic        zero_o    [3];

    int total = 0;
    int bad   = 0;
    int lat_exp [3] = '{4, 1, 16};

    addn_seq #(.WIDTH(16), .CHUNK(4)) u_c4 (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .op_a(op_a), .op_b(op_b), .cyi(cyi), .sub(sub),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .sum(sum_o[0]),
        .cyo(cyo_o[0]), .ovf(ovf_o[0]), .neg(neg_o[0]), .zero(zero_o[0])
    );

    addn_seq #(.WIDTH(16), .CHUNK(16)) u_c16 (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .op_a(op_a), .op_b(op_b), .cyi(cyi), .sub(sub),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .sum(sum_o[1]),
        .cyo(cyo_o[1]), .ovf(ovf_o[1]), .neg(neg_o[1]), .zero(zero_o[1])
    );

    addn_seq #(.WIDTH(16), .CHUNK(1)) u_c1 (
        .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .op_a(op_a), .op_b(op_b), .cyi(cyi), .sub(sub),
        .out_valid(out_valid[2]), .out_ready(out_ready[2]), .sum(sum_o[2]),
        .cyo(cyo_o[2]), .ovf(ovf_o[2]), .neg(neg_o[2]), .zero(zero_o[2])
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on unsigned and signed views of the operands.
    task automatic model(input logic [15:0] a, input logic [15:0] b, input logic c, input logic s,
                         output logic [15:0] es, output logic ecy, output logic eov);
        int ua, ub, sa, sb, ci, r, sr;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        ci = c ? 1 : 0;
        if (!s) begin
            r   = ua + ub + ci;
            sr  = sa + sb + ci;
            ecy = (r > 65535);
        end else begin
            r   = ua - ub - ci;
            sr  = sa - sb - ci;
            ecy = (r >= 0);
        end
        es  = r[15:0];
        eov = (sr > 32767) || (sr < -32768);
    endtask

    task automatic wait_out(input int k, output int n);
        n = 0;
        while (!out_valid[k] && n < 40) begin
            tick();
            n++;
        end
    endtask

    task automatic check_result(input int k, input string tag, input logic [15:0] a, input logic [15:0] b,
                                input logic c, input logic s, output logic [15:0] es);
        logic ecy, eov;
        model(a, b, c, s, es, ecy, eov);
        chk({tag, " sum"},  sum_o[k],  es);
        chk({tag, " cyo"},  cyo_o[k],  ecy);
        chk({tag, " ovf"},  ovf_o[k],  eov);
        chk({tag, " neg"},  neg_o[k],  es[15]);
        chk({tag, " zero"}, zero_o[k], (es == 16'h0));
    endtask

    task automatic transact(input int k, input string tag, input logic [15:0] a, input logic [15:0] b,
                            input logic c, input logic s, input int maxhold,
                            input bit dir, input logic [15:0] dsum, input logic dcyo, input logic dovf);
        int n, h;
        logic [15:0] es;
        op_a = a; op_b = b; cyi = c; sub = s;
        in_valid[k] = 1'b1;
        out_ready[k] = 1'b0;
        chk({tag, " in_ready"}, in_ready[k], 1'b1);
        tick();
        in_valid[k] = 1'b0;
        op_a = 16'($urandom); op_b = 16'($urandom); cyi = 1'($urandom); sub = 1'($urandom);
        wait_out(k, n);
        chk({tag, " latency"}, n, lat_exp[k]);
        check_result(k, tag, a, b, c, s, es);
        if (dir) begin
            chk({tag, " const sum"}, sum_o[k], dsum);
            chk({tag, " const cyo"}, cyo_o[k], dcyo);
            chk({tag, " const ovf"}, ovf_o[k], dovf);
        end
        h = $urandom_range(0, maxhold);
        for (int i = 0; i < h; i++) begin
            tick();
            chk({tag, " hold valid"}, out_valid[k], 1'b1);
            chk({tag, " hold sum"}, sum_o[k], es);
        end
        out_ready[k] = 1'b1;
        tick();
        out_ready[k] = 1'b0;
        chk({tag, " valid drop"}, out_valid[k], 1'b0);
        chk({tag, " back idle"}, in_ready[k], 1'b1);
    endtask

    initial begin
        int n;
        logic [15:0] es;

        rst = 1'b1;
        op_a = '0; op_b = '0; cyi = 1'b0; sub = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid[k] = 1'b0;
            out_ready[k] = 1'b0;
        end
        tick();
        tick();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("reset in_ready %0d", k), in_ready[k], 1'b1);
            chk($sformatf("reset out_valid %0d", k), out_valid[k], 1'b0);
            chk($sformatf("reset outs %0d", k),
                {sum_o[k], cyo_o[k], ovf_o[k], neg_o[k], zero_o[k]}, 32'h0);
        end

        transact(0, "add 1111+1111", 16'h1111, 16'h1111, 1'b0, 1'b0, 0, 1, 16'h2222, 1'b0, 1'b0);
        transact(0, "add 7fff+1",    16'h7FFF, 16'h0001, 1'b0, 1'b0, 0, 1, 16'h8000, 1'b0, 1'b1);
        transact(0, "add ffff+1",    16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, 1, 16'h0000, 1'b1, 1'b0);
        transact(0, "sub 1234-1234", 16'h1234, 16'h1234, 1'b0, 1'b1, 0, 1, 16'h0000, 1'b1, 1'b0);
        transact(0, "sub 0-1",       16'h0000, 16'h0001, 1'b0, 1'b1, 0, 1, 16'hFFFF, 1'b0, 1'b0);
        transact(0, "sub 8000-1",    16'h8000, 16'h0001, 1'b0, 1'b1, 0, 1, 16'h7FFF, 1'b1, 1'b1);

        // Backpressure with a competing request held on the input.
        op_a = 16'h4000; op_b = 16'h4000; cyi = 1'b0; sub = 1'b0;
        in_valid[0] = 1'b1;
        tick();
        in_valid[0] = 1'b0;
        wait_out(0, n);
        chk("bp latency", n, 4);
        op_a = 16'h0003; op_b = 16'h0005; cyi = 1'b0; sub = 1'b1;
        in_valid[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("bp sum held", sum_o[0], 16'h8000);
            chk("bp ovf held", ovf_o[0], 1'b1);
            chk("bp neg held", neg_o[0], 1'b1);
            chk("bp in_ready", in_ready[0], 1'b0);
            chk("bp out_valid", out_valid[0], 1'b1);
            tick();
        end
        out_ready[0] = 1'b1;
        tick();
        out_ready[0] = 1'b0;
        chk("bp drop valid", out_valid[0], 1'b0);
        chk("bp idle ready", in_ready[0], 1'b1);
        chk("bp sum kept", sum_o[0], 16'h8000);
        tick();
        in_valid[0] = 1'b0;
        chk("bp second taken", in_ready[0], 1'b0);
        wait_out(0, n);
        chk("bp second latency", n, 4);
        check_result(0, "bp second", 16'h0003, 16'h0005, 1'b0, 1'b1, es);
        chk("bp second const", sum_o[0], 16'hFFFE);
        out_ready[0] = 1'b1;
        tick();
        out_ready[0] = 1'b0;

        // Reset during the second BUSY cycle.
        op_a = 16'h1111; op_b = 16'h2222; cyi = 1'b0; sub = 1'b0;
        in_valid[0] = 1'b1;
        tick();
        in_valid[0] = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst mid in_ready", in_ready[0], 1'b1);
        chk("rst mid out_valid", out_valid[0], 1'b0);
        chk("rst mid outs", {sum_o[0], cyo_o[0], ovf_o[0], neg_o[0], zero_o[0]}, 32'h0);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("rst no spurious valid", out_valid[0], 1'b0);
        end
        transact(0, "after rst", 16'h1111, 16'h0000, 1'b1, 1'b0, 0, 1, 16'h1112, 1'b0, 1'b0);

        // Random ADD/SUB runs on each chunk configuration, random output backpressure.
        for (int k = 0; k < 3; k++) begin
            for (int v = 0; v < 1000; v++) begin
                transact(k, $sformatf("rnd k%0d v%0d", k, v), 16'($urandom), 16'($urandom),
                         1'($urandom), 1'($urandom), 2, 0, 16'h0, 1'b0, 1'b0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
